// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: instruction port, data port, program-load handshake and shared RAM.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_odv;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_odv;
  logic          ld_en;
  logic [DW-1:0] bus_in;
  logic          hs_in;
  logic          hs_out;
  logic [AW-1:0] ld_ptr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_en, bus_in, hs_in, ram_rdata,
    output i_rdata, i_odv, d_rdata, d_odv, hs_out, ld_ptr, ram_addr, ram_wdata, ram_we,
           ram_re, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_en, bus_in, hs_in, ram_rdata,
    input  i_rdata, i_odv, d_rdata, d_odv, hs_out, ld_ptr, ram_addr, ram_wdata, ram_we,
           ram_re, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way arbiter (program load > data > instruction) in front of a single-port RAM.
// Define ARB_ROUND_ROBIN_EN to alternate data/instruction priority instead of fixed data-first.
module mem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input logic         g_clk,
  input logic         g_clr,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp, StHsWait} state_e;
  typedef enum logic [1:0] {GntI, GntD, GntL} gnt_e;

  state_e        state_q;
  gnt_e          gnt_q;
  logic          we_q;
  logic [AW-1:0] ld_ptr_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          ram_we_q;
  logic          ram_re_q;
  logic          hs_out_q;
  logic          busy_q;
  logic          i_odv_q;
  logic          d_odv_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic load_req;
  logic pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q;  // 1: data was granted last, so instruction wins a tie next
  always_comb begin
    load_req = bus.ld_en & bus.hs_in;
    pick_d   = bus.d_req & (~bus.i_req | ~last_d_q);
  end
`else
  always_comb begin
    load_req = bus.ld_en & bus.hs_in;
    pick_d   = bus.d_req;
  end
`endif

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q     <= StIdle;
      gnt_q       <= GntI;
      we_q        <= 1'b0;
      ld_ptr_q    <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      hs_out_q    <= 1'b0;
      busy_q      <= 1'b0;
      i_odv_q     <= 1'b0;
      d_odv_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      i_odv_q <= 1'b0;
      d_odv_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_req) begin
            gnt_q       <= GntL;
            we_q        <= 1'b1;
            ram_addr_q  <= ld_ptr_q;
            ram_wdata_q <= bus.bus_in;
            ram_we_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StIssue;
          end else if (pick_d) begin
            gnt_q      <= GntD;
            we_q       <= bus.d_we;
            ram_addr_q <= bus.d_addr;
            if (bus.d_we) begin
              ram_wdata_q <= bus.d_wdata;
              ram_we_q    <= 1'b1;
            end else begin
              ram_re_q <= 1'b1;
            end
            busy_q  <= 1'b1;
            state_q <= StIssue;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b1;
`endif
          end else if (bus.i_req) begin
            gnt_q      <= GntI;
            we_q       <= 1'b0;
            ram_addr_q <= bus.i_addr;
            ram_re_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
          end
        end
        StIssue: begin
          ram_we_q <= 1'b0;
          ram_re_q <= 1'b0;
          if (gnt_q == GntL) begin
            hs_out_q <= 1'b1;
            state_q  <= StHsWait;
          end else begin
            state_q <= StResp;
          end
        end
        StResp: begin
          // ram_rdata is valid now, one cycle after the read strobe
          if (gnt_q == GntD) begin
            d_odv_q <= 1'b1;
            if (!we_q) d_rdata_q <= bus.ram_rdata;
          end else begin
            i_odv_q   <= 1'b1;
            i_rdata_q <= bus.ram_rdata;
          end
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StHsWait: begin
          if (!bus.hs_in) begin
            hs_out_q <= 1'b0;
            ld_ptr_q <= ld_ptr_q + AW'(1);
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_odv     = i_odv_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_odv     = d_odv_q;
  assign bus.hs_out    = hs_out_q;
  assign bus.ld_ptr    = ld_ptr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected RAM writes and port responses are queued at
// stimulus time and compared when the DUT strobes them.
module tb_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic g_clk = 1'b0;
  logic g_clr = 1'b0;
  always #5 g_clk = ~g_clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.g_clk(g_clk), .g_clr(g_clr), .bus(bus));

  typedef struct packed {logic is_d; logic [7:0] data;} resp_t;
  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t mon_r;
  wr_t   mon_w;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] mem [256];
  bit         written [256];
  logic [7:0] ref_mem [256];
  bit         ref_written [256];
  logic [7:0] ld_ptr_model;
  logic [7:0] last_d;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    return ref_written[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Synchronous RAM: read data appears the cycle after ram_re
  always @(posedge g_clk) begin
    if (bus.ram_re) bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr]
                                                           : init_val(bus.ram_addr);
    if (bus.ram_we) begin
      mem[bus.ram_addr]     <= bus.ram_wdata;
      written[bus.ram_addr] <= 1'b1;
    end
  end

  always @(negedge g_clk) begin
    if (g_clr) begin
      if (bus.ram_we || bus.ram_re) check("we_re_excl", 32'(bus.ram_we & bus.ram_re), 0);
      if (bus.ram_we) begin
        if (wr_q.size() == 0) check("unexp_write", 1, 0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(mon_w.addr));
          check("wr_data", 32'(bus.ram_wdata), 32'(mon_w.data));
        end
      end
      if (bus.i_odv || bus.d_odv) begin
        if (resp_q.size() == 0) check("unexp_odv", 1, 0);
        else begin
          mon_r = resp_q.pop_front();
          check("odv_port", 32'(bus.d_odv), 32'(mon_r.is_d));
          check("rdata", 32'(mon_r.is_d ? bus.d_rdata : bus.i_rdata), 32'(mon_r.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check("drain", resp_q.size() + wr_q.size(), 0);
    resp_q.delete();
    wr_q.delete();
  endtask

  task automatic check_reset();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_i_odv", 32'(bus.i_odv), 0);
    check("rst_d_odv", 32'(bus.d_odv), 0);
    check("rst_hs_out", 32'(bus.hs_out), 0);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_re", 32'(bus.ram_re), 0);
    check("rst_ld_ptr", 32'(bus.ld_ptr), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
    check("rst_i_rdata", 32'(bus.i_rdata), 0);
    check("rst_d_rdata", 32'(bus.d_rdata), 0);
  endtask

  task automatic do_load(input logic [7:0] val, input bit drop_ld, input bit detail);
    int n = 0;
    wr_q.push_back({ld_ptr_model, val});
    ref_mem[ld_ptr_model]     = val;
    ref_written[ld_ptr_model] = 1'b1;
    bus.ld_en  = 1'b1;
    bus.bus_in = val;
    bus.hs_in  = 1'b1;
    tick();
    if (detail) begin
      check("ld_issue_we", 32'(bus.ram_we), 1);
      check("ld_issue_hs", 32'(bus.hs_out), 0);
      check("ld_issue_addr", 32'(bus.ram_addr), 32'(ld_ptr_model));
    end
    while (!bus.hs_out && n < 10) begin
      tick();
      n++;
    end
    check("hs_rise", 32'(bus.hs_out), 1);
    if (detail) check("hs_rise_delay", n, 1);
    if (drop_ld) bus.ld_en = 1'b0;
    tick();
    check("hs_hold", 32'(bus.hs_out), 1);
    bus.hs_in = 1'b0;
    tick();
    ld_ptr_model = ld_ptr_model + 8'd1;
    check("hs_fall", 32'(bus.hs_out), 0);
    check("ld_ptr", 32'(bus.ld_ptr), 32'(ld_ptr_model));
    bus.ld_en = 1'b0;
  endtask

  initial begin
    int n;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.ld_en = 1'b0; bus.bus_in = '0; bus.hs_in = 1'b0;
    ld_ptr_model = 8'h00;
    last_d = 8'h00;

    repeat (2) tick();
    check_reset();
    g_clr = 1'b1;
    tick();

    // Single instruction read
    bus.i_addr = 8'h10;
    bus.i_req  = 1'b1;
    resp_q.push_back({1'b0, 8'hA5});
    tick();
    bus.i_req = 1'b0;
    check("t1_re", 32'(bus.ram_re), 1);
    check("t1_we", 32'(bus.ram_we), 0);
    check("t1_addr", 32'(bus.ram_addr), 32'h10);
    check("t1_busy", 32'(bus.busy), 1);
    tick();
    check("t1_re_off", 32'(bus.ram_re), 0);
    tick();
    check("t1_odv", 32'(bus.i_odv), 1);
    check("t1_rdata", 32'(bus.i_rdata), 32'hA5);
    tick();
    check("t1_odv_pulse", 32'(bus.i_odv), 0);
    check("t1_hold", 32'(bus.i_rdata), 32'hA5);
    check("t1_idle", 32'(bus.busy), 0);
    drain();

    // Data write
    bus.d_addr = 8'h03; bus.d_wdata = 8'h5C; bus.d_we = 1'b1; bus.d_req = 1'b1;
    wr_q.push_back({8'h03, 8'h5C});
    resp_q.push_back({1'b1, last_d});
    ref_mem[8'h03] = 8'h5C; ref_written[8'h03] = 1'b1;
    tick();
    bus.d_req = 1'b0;
    check("t2_we", 32'(bus.ram_we), 1);
    check("t2_re", 32'(bus.ram_re), 0);
    check("t2_addr", 32'(bus.ram_addr), 32'h03);
    check("t2_wdata", 32'(bus.ram_wdata), 32'h5C);
    tick();
    check("t2_we_off", 32'(bus.ram_we), 0);
    check("t2_wdata_hold", 32'(bus.ram_wdata), 32'h5C);
    tick();
    check("t2_odv", 32'(bus.d_odv), 1);
    check("t2_drdata_hold", 32'(bus.d_rdata), 32'(last_d));
    drain();

    // Contending data and instruction reads held for 12 cycles
    bus.d_we = 1'b0; bus.d_addr = 8'h20; bus.i_addr = 8'h21;
    for (int k = 0; k < 4; k++) begin
      if (RrEn && (k % 2 == 1)) resp_q.push_back({1'b0, exp_rd(8'h21)});
      else resp_q.push_back({1'b1, exp_rd(8'h20)});
    end
    last_d = exp_rd(8'h20);
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    repeat (12) tick();
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    drain();

    // Walk the load pointer up to 0xFE, dropping ld_en mid-handshake once
    for (int i = 0; i < 254; i++) do_load(8'(i) ^ 8'hC3, i == 5, 1'b0);
    check("ld_ptr_fe", 32'(bus.ld_ptr), 32'hFE);
    do_load(8'h11, 1'b0, 1'b1);
    do_load(8'h22, 1'b0, 1'b1);
    check("ld_ptr_wrap", 32'(bus.ld_ptr), 32'h00);
    drain();
    bus.i_addr = 8'hFE; bus.i_req = 1'b1;
    resp_q.push_back({1'b0, exp_rd(8'hFE)});
    tick();
    bus.i_req = 1'b0;
    drain();

    // Load and data read together: load first, data after the handshake
    wr_q.push_back({ld_ptr_model, 8'h77});
    ref_mem[ld_ptr_model] = 8'h77; ref_written[ld_ptr_model] = 1'b1;
    ld_ptr_model = ld_ptr_model + 8'd1;
    resp_q.push_back({1'b1, exp_rd(8'h20)});
    bus.ld_en = 1'b1; bus.hs_in = 1'b1; bus.bus_in = 8'h77;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h20;
    tick();
    check("t5_load_we", 32'(bus.ram_we), 1);
    check("t5_load_re", 32'(bus.ram_re), 0);
    n = 0;
    while (!bus.hs_out && n < 10) begin tick(); n++; end
    check("t5_hs_rise", 32'(bus.hs_out), 1);
    check("t5_no_dodv", 32'(bus.d_odv), 0);
    bus.hs_in = 1'b0; bus.ld_en = 1'b0;
    n = 0;
    while (!bus.ram_re && n < 10) begin tick(); n++; end
    check("t5_d_grant", 32'(bus.ram_re), 1);
    bus.d_req = 1'b0;
    drain();

    // Reset during RESP of a read
    bus.i_addr = 8'h30; bus.i_req = 1'b1;
    tick();
    bus.i_req = 1'b0;
    tick();
    check("t6_busy_resp", 32'(bus.busy), 1);
    #2 g_clr = 1'b0;
    #1 check_reset();
    ld_ptr_model = 8'h00;
    tick();
    g_clr = 1'b1;
    repeat (3) begin
      tick();
      check("t6_no_odv", 32'(bus.i_odv), 0);
    end
    bus.i_req = 1'b1;
    resp_q.push_back({1'b0, exp_rd(8'h30)});
    tick();
    bus.i_req = 1'b0;
    check("t6_re", 32'(bus.ram_re), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
